// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD (0..399) to binary converter using reverse double-dabble,
// one bit per clock, with a start/busy/done handshake and overflow/invalid-digit flags.
module bcd_to_binary_seq #(
  parameter bit SAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       START,
  input  logic [1:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] BIN,
  output logic       OVF,
  output logic       ERR
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [18:0] sr_q, sr_d;      // {H[1:0], T[3:0], O[3:0], R[8:0]}
  logic [3:0]  cnt_q, cnt_d;
  logic        errl_q, errl_d;
  logic        done_q, done_d;
  logic [7:0]  bin_q, bin_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic [18:0] sh;
  logic [3:0]  t_fix, o_fix;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 4'd8) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = (state_q != S_IDLE);
    DONE = done_q;
    BIN  = bin_q;
    OVF  = ovf_q;
    ERR  = err_q;
  end

  // Shift right, then pull each BCD column that reached 8 back down by 3
  always_comb begin
    sh    = {1'b0, sr_q[18:1]};
    t_fix = (sh[16:13] >= 4'd8) ? sh[16:13] - 4'd3 : sh[16:13];
    o_fix = (sh[12:9]  >= 4'd8) ? sh[12:9]  - 4'd3 : sh[12:9];
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    errl_d = errl_q;
    done_d = 1'b0;
    bin_d  = bin_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: if (START) begin
        sr_d   = {HUNDREDS, TENS, ONES, 9'b0};
        cnt_d  = 4'd0;
        errl_d = (TENS > 4'd9) || (ONES > 4'd9);
      end
      S_SHIFT: begin
        sr_d  = {sh[18:17], t_fix, o_fix, sh[8:0]};
        cnt_d = cnt_q + 4'd1;
      end
      S_FIN: begin
        done_d = 1'b1;
        err_d  = errl_q;
        ovf_d  = !errl_q && sr_q[8];
        if (errl_q)              bin_d = 8'h00;
        else if (sr_q[8] && SAT) bin_d = 8'hFF;
        else                     bin_d = sr_q[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      errl_q <= 1'b0;
      done_q <= 1'b0;
      bin_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      errl_q <= errl_d;
      done_q <= done_d;
      bin_q  <= bin_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential 3-digit BCD to 8-bit binary converter, the inverse of the LCD path's binary-to-BCD conversion. It uses reverse double-dabble: shift right, then subtract 3 from each BCD column that is 8 or more, one bit per clock. It sits between keypad/LCD digit entry and datapath registers that consume binary values 0..255. A start/busy/done handshake is used, with fixed latency, plus overflow and invalid-digit flags.

Parameters:
SAT, 1, overflow policy: 1 = BIN saturates to 8'hFF on overflow; 0 = BIN holds the low 8 bits of the 9-bit result.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
START  input  1  conversion request; sampled only in IDLE.
HUNDREDS  input  2  BCD hundreds digit (0..3); captured when START is accepted.
TENS  input  4  BCD tens digit; captured when START is accepted.
ONES  input  4  BCD ones digit; captured when START is accepted.
BUSY  output  1  high while a conversion is in progress (SHIFT or FIN).
DONE  output  1  one-cycle pulse; BIN/OVF/ERR are valid and updated in this cycle.
BIN  output  8  binary result; held until the next DONE.
OVF  output  1  the input value was greater than 255.
ERR  output  1  TENS or ONES was greater than 9.

Behaviour:
- Reset, asynchronous and active-high: state goes to IDLE; BUSY=0, DONE=0, BIN=0, OVF=0, ERR=0; shift register and counter are cleared.
- Datapath: 19-bit register {H[1:0], T[3:0], O[3:0], R[8:0]}; 4-bit iteration counter.
- States and transitions:
  - IDLE:
    - On START=1 at edge k: load {HUNDREDS, TENS, ONES, 9'b0}; cnt=0.
    - Latch err_i = (TENS>9) or (ONES>9). Go to SHIFT.
    - BUSY=1 from edge k.
  - SHIFT, edges k+1..k+9 (9 iterations):
    - Logical right shift of all 19 bits.
    - Then, independently, for the T and O columns: if the column value is 8 or more, subtract 3.
    - H needs no correction: it is 2 bits and cannot reach 8.
    - cnt increments each edge; after the 9th shift (cnt was 8), go to FIN.
  - FIN, edge k+10:
    - OVF = R[8] or (R[7:0]>255), i.e. R>255.
    - BIN = 0 if err_i; else 8'hFF if OVF and SAT=1; else R[7:0].
    - ERR = err_i. When err_i=1, OVF is forced to 0.
    - DONE=1 for exactly one cycle. BUSY=0. Go to IDLE.
- Latency: DONE is high in the cycle after edge k+10, i.e. 10 clocks after START is accepted. Latency is the same for every input, including error inputs.
- START while BUSY=1 is ignored; no queuing.
- START high in the same cycle as DONE is accepted, since the state is IDLE then. Back-to-back conversions therefore run every 11 cycles.
- Input digits are captured at acceptance only; changes to them during BUSY have no effect.
- BIN, OVF and ERR are registered and hold their values between DONE pulses.
- Reset asserted mid-conversion: the conversion aborts, no DONE is produced, and all outputs go to their reset values.
- HUNDREDS=3 is a legal BCD digit but always sets OVF (300..399).
- Column correction is combinational within the iteration cycle. No arithmetic wider than 4 bits per column.

Test Plan:
- Zero and max: input 0,0,0 -> DONE 10 cycles after START, BIN=0x00, OVF=0, ERR=0. Input 2,5,5 -> BIN=0xFF, OVF=0.
- Mid-range sweep: input 1,2,3 -> BIN=0x7B. Input 0,1,0 -> BIN=0x0A. Exhaustively compare all 256 legal values against a reference model.
- Overflow:
  - Input 2,5,6 with SAT=1 -> BIN=0xFF, OVF=1.
  - Same input with SAT=0 -> BIN=0x00, OVF=1.
  - Input 3,9,9 with SAT=0 -> BIN=0x8F, OVF=1.
- Invalid digit: TENS=4'hA or ONES=4'hF -> DONE after 10 cycles, ERR=1, BIN=0, OVF=0.
- Handshake:
  - START pulsed again at cycles 3 and 9 while busy -> ignored; exactly one DONE.
  - START held high across DONE -> second conversion accepted, second DONE 11 cycles after the first.
- Reset: assert rst at cycle 5 of a conversion -> BUSY, DONE, BIN, OVF and ERR go to 0 immediately (asynchronously); no DONE follows. After release, a fresh START converts correctly.
